// File: rtl/alien_march.sv
// Alien formation marcher: one horizontal step (or edge drop + reversal) per accepted
// divider tick, with a sticky invaded flag once the formation reaches the player row.
module alien_march #(
  parameter int COL_W   = 16,
  parameter int X_MIN   = 0,
  parameter int X_MAX   = 639,
  parameter int STEP_X  = 2,
  parameter int STEP_Y  = 8,
  parameter int X_INIT  = 64,
  parameter int Y_INIT  = 32,
  parameter int Y_LIMIT = 400,
  parameter int XW      = 11,
  parameter int YW      = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 en,
  input  logic                 none_alive,
  input  logic [3:0]           left_col,
  input  logic [3:0]           right_col,
  output logic signed [XW-1:0] x_off,
  output logic [YW-1:0]        y_off,
  output logic                 dir,
  output logic                 frame,
  output logic                 step_done,
  output logic                 invaded
);

  localparam int EW = XW + 6;

  typedef enum logic [1:0] {WAIT, EVAL, APPLY, HALT} state_t;

  state_t state, state_nxt;

  logic [3:0]          lcol_p0, rcol_p0;
  logic                drop_p1;
  logic                accept;
  logic signed [EW-1:0] x_ext, lcol_px, rcol_px, le, re;
  logic                drop_nxt;
  logic [YW-1:0]       y_new;
  logic                hit_limit;

  function automatic logic [YW-1:0] sat_add_y(input logic [YW-1:0] a,
                                              input logic [YW-1:0] b);
    logic [YW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[YW] ? '1 : s[YW-1:0];
  endfunction

  // An inverted column range means nothing is alive, so the tick is ignored.
  assign accept = tick & en & ~none_alive & (left_col <= right_col);

  always_comb begin
    x_ext    = {{6{x_off[XW-1]}}, x_off};
    lcol_px  = $signed(EW'(lcol_p0)) * $signed(EW'(COL_W));
    rcol_px  = $signed(EW'(rcol_p0) + EW'(1)) * $signed(EW'(COL_W));
    le       = x_ext + lcol_px;
    re       = x_ext + rcol_px - EW'(1);
    drop_nxt = dir ? (le - EW'(STEP_X) < EW'(X_MIN))
                   : (re + EW'(STEP_X) > EW'(X_MAX));
    y_new     = drop_p1 ? sat_add_y(y_off, YW'(STEP_Y)) : y_off;
    hit_limit = (y_new >= YW'(Y_LIMIT));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT:    if (accept) state_nxt = EVAL;
      EVAL:    state_nxt = APPLY;
      APPLY:   state_nxt = hit_limit ? HALT : WAIT;
      HALT:    state_nxt = HALT;
      default: state_nxt = WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WAIT;
      lcol_p0   <= '0;
      rcol_p0   <= '0;
      drop_p1   <= 1'b0;
      x_off     <= XW'(X_INIT);
      y_off     <= YW'(Y_INIT);
      dir       <= 1'b0;
      frame     <= 1'b0;
      step_done <= 1'b0;
      invaded   <= 1'b0;
    end else begin
      state     <= state_nxt;
      step_done <= (state == APPLY);
      // Stage p0: capture the alive column span with the tick
      if (state == WAIT && accept) begin
        lcol_p0 <= left_col;
        rcol_p0 <= right_col;
      end
      // Stage p1: edge test against the current origin
      if (state == EVAL)
        drop_p1 <= drop_nxt;
      // Stage p2: commit the step
      if (state == APPLY) begin
        frame <= ~frame;
        if (drop_p1) begin
          y_off <= y_new;
          dir   <= ~dir;
        end else begin
          x_off <= dir ? x_off - XW'(STEP_X) : x_off + XW'(STEP_X);
        end
        if (hit_limit)
          invaded <= 1'b1;
      end
    end
  end

endmodule
